fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation uCISC core.
- Generalises the fixed 4-step fetch (step counter, pc register, two-word instruction register) into a decoupled unit:
  - variable-latency memory request/acknowledge handshake;
  - prefetch queue of configurable depth;
  - valid/ready hand-off to the execute stage;
  - redirect (PC store) flush.
- Sits between the memory block port and the core's decode/execute logic.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_unit_instr_queue.sv | 85 ++++++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and sizing helpers for the uCISC fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO, DRAIN} fetch_state_t;

  localparam int INSTR_WORDS = 2;

  function automatic int instr_width(input int word_width);
    return INSTR_WORDS * word_width;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_unit_instr_queue.sv
// Shift-register FIFO for prefetched instructions.
// Entry 0 is always the head, so the head comes straight from a register.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2,
  localparam int CW = level_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] slots      [DEPTH];
  logic [WIDTH-1:0] next_slots [DEPTH];
  logic             do_pop;
  logic             do_push;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    next_count;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_idx  = do_pop ? count - ONE_C : count;
  assign head    = slots[0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      next_slots[i] = slots[i];
    end
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        next_slots[i] = slots[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (CW'(i) == wr_idx)) begin
        next_slots[i] = push_data;
      end
    end
  end

  always_comb begin
    next_count = count;
    if (do_push && !do_pop) begin
      next_count = count + ONE_C;
    end else if (do_pop && !do_push) begin
      next_count = count - ONE_C;
    end
  end

  // Flush only clears occupancy; stale storage keeps ir/ir_pc stable while invalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= next_slots[i];
      end
      count <= next_count;
      full  <= (next_count == DEPTH_C);
      empty <= (next_count == '0);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: two-word memory reads feed a prefetch queue that
// is handed to execute with valid/ready; a redirect flushes and restarts fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  localparam int                   IW          = instr_width(WORD_WIDTH),
  localparam int                   LW          = level_width(QUEUE_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ir_valid,
  output logic [IW-1:0]         ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  ir_ready,
  output logic [LW-1:0]         level,
  output logic                  proto_err
);

  localparam int                    QW       = IW + ADDR_WIDTH;
  localparam logic [LW-1:0]         DEPTH_M1 = LW'(QUEUE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO   = ADDR_WIDTH'(2);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [WORD_WIDTH-1:0] hi_word;
  logic                  pop;
  logic                  push;
  logic                  q_full;
  logic                  q_empty;
  logic                  free_now;
  logic                  free_after_push;
  logic [QW-1:0]         q_head;

  assign pop  = ~q_empty & ir_ready & ~redirect;
  assign push = (state == LO) & mem_ack & ~redirect;

  // A new fetch may only start if the instruction it produces is guaranteed a slot.
  assign free_now        = ~q_full | pop;
  assign free_after_push = (level < DEPTH_M1) | pop;

  assign ir_valid = ~q_empty;
  assign ir       = q_head[QW-1:ADDR_WIDTH];
  assign ir_pc    = q_head[ADDR_WIDTH-1:0];

  instr_queue #(
    .WIDTH (QW),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data ({hi_word, mem_data, fetch_pc}),
    .head      (q_head),
    .count     (level),
    .full      (q_full),
    .empty     (q_empty)
  );

  // In DRAIN, fetch_pc already holds the redirect target to resume from.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= RESET_PC;
      fetch_pc  <= RESET_PC;
      hi_word   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (mem_ack && !mem_req) begin
        proto_err <= 1'b1;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        if (mem_req && !mem_ack) begin
          state <= DRAIN;
        end else begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (free_now) begin
              mem_req  <= 1'b1;
              mem_addr <= fetch_pc;
              state    <= HI;
            end
          end
          HI: begin
            if (mem_ack) begin
              hi_word  <= mem_data;
              mem_addr <= fetch_pc + PC_ONE;
              state    <= LO;
            end
          end
          LO: begin
            if (mem_ack) begin
              fetch_pc <= fetch_pc + PC_TWO;
              if (free_after_push) begin
                mem_addr <= fetch_pc + PC_TWO;
                state    <= HI;
              end else begin
                mem_req <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          DRAIN: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
          default: begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model feeds two
// DUT instances (reset PC 0 and 0xFFFE); consumed instructions are checked in order.
module tb_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] instr;
  } exp_entry_t;

  logic        clock = 1'b0;
  logic        reset_a;
  logic        reset_b;
  logic        sel;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_ready;
  logic        manual_ack;
  int          latency;

  logic        a_mem_req,   b_mem_req;
  logic [15:0] a_mem_addr,  b_mem_addr;
  logic        a_ir_valid,  b_ir_valid;
  logic [31:0] a_ir,        b_ir;
  logic [15:0] a_ir_pc,     b_ir_pc;
  logic [1:0]  a_level,     b_level;
  logic        a_proto_err, b_proto_err;

  logic        reset_cur;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        ir_valid;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic [1:0]  level;
  logic        proto_err;

  exp_entry_t  exp_q[$];
  logic [15:0] ack_addr_q[$];
  int          cyc = 0;
  int          last_ack_cyc = 0;
  int          pops_seen = 0;
  int          ack_cnt = 0;
  int          n_checks = 0;
  int          n_fails = 0;

  assign reset_cur = sel ? reset_b     : reset_a;
  assign mem_req   = sel ? b_mem_req   : a_mem_req;
  assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign ir_valid  = sel ? b_ir_valid  : a_ir_valid;
  assign ir        = sel ? b_ir        : a_ir;
  assign ir_pc     = sel ? b_ir_pc     : a_ir_pc;
  assign level     = sel ? b_level     : a_level;
  assign proto_err = sel ? b_proto_err : a_proto_err;

  fetch_unit #(
    .ADDR_WIDTH (16), .WORD_WIDTH (16), .QUEUE_DEPTH (2), .RESET_PC (16'h0000)
  ) dut_a (
    .clock (clock), .reset (reset_a),
    .mem_req (a_mem_req), .mem_addr (a_mem_addr), .mem_ack (mem_ack), .mem_data (mem_data),
    .redirect (redirect), .redirect_pc (redirect_pc),
    .ir_valid (a_ir_valid), .ir (a_ir), .ir_pc (a_ir_pc), .ir_ready (ir_ready),
    .level (a_level), .proto_err (a_proto_err)
  );

  fetch_unit #(
    .ADDR_WIDTH (16), .WORD_WIDTH (16), .QUEUE_DEPTH (2), .RESET_PC (16'hFFFE)
  ) dut_b (
    .clock (clock), .reset (reset_b),
    .mem_req (b_mem_req), .mem_addr (b_mem_addr), .mem_ack (mem_ack), .mem_data (mem_data),
    .redirect (redirect), .redirect_pc (redirect_pc),
    .ir_valid (b_ir_valid), .ir (b_ir), .ir_pc (b_ir_pc), .ir_ready (ir_ready),
    .level (b_level), .proto_err (b_proto_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'h5678;
      default:  return {a[7:0] ^ 8'h3C, a[15:8] ^ a[7:0] ^ 8'hA5};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rd, input logic [15:0] rd_pc);
    ir_ready    = rdy;
    redirect    = rd;
    redirect_pc = rd_pc;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expectStream(input logic [15:0] start, input int n);
    logic [15:0] p;
    exp_entry_t  e;
    p = start;
    for (int i = 0; i < n; i++) begin
      e.pc    = p;
      e.instr = {mem_word(p), mem_word(p + 16'd1)};
      exp_q.push_back(e);
      p = p + 16'd2;
    end
  endtask

  // Memory responder: ack after `latency` extra cycles of a held request.
  always @(posedge clock) begin
    #2;
    if (reset_cur) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (manual_ack) begin
      mem_ack  = 1'b1;
      mem_data = 16'hDEAD;
      ack_cnt  = 0;
    end else if (mem_req) begin
      if (ack_cnt == latency) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
        ack_addr_q.push_back(mem_addr);
        last_ack_cyc = cyc;
        ack_cnt  = 0;
      end else begin
        mem_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  // Execute-side monitor: every consumed instruction must match the next expected one.
  always @(negedge clock) begin
    exp_entry_t e;
    if (!reset_cur && ir_valid && ir_ready && !redirect) begin
      pops_seen++;
      checkOutput("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_ir_pc", 64'(ir_pc), 64'(e.pc));
        checkOutput("sb_ir", 64'(ir), 64'(e.instr));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks_before;
    reset_a = 1'b1; reset_b = 1'b1; sel = 1'b0;
    manual_ack = 1'b0; latency = 1; mem_ack = 1'b0; mem_data = '0;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycles(2);

    // Basic fetch of instruction 0 with one-cycle ack latency
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0000);
    checkOutput("rst_ir_valid", 64'(ir_valid), 64'd0);
    checkOutput("rst_ir", 64'(ir), 64'd0);
    checkOutput("rst_ir_pc", 64'(ir_pc), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'h0000, 32);
    reset_a = 1'b0;
    for (int i = 0; i < 20 && !ir_valid; i++) stepCycles(1);
    checkOutput("t1_ir_valid", 64'(ir_valid), 64'd1);
    checkOutput("t1_ack_count", 64'(ack_addr_q.size()), 64'd2);
    if (ack_addr_q.size() >= 2) begin
      checkOutput("t1_ack0_addr", 64'(ack_addr_q[0]), 64'h0000);
      checkOutput("t1_ack1_addr", 64'(ack_addr_q[1]), 64'h0001);
    end
    checkOutput("t1_valid_latency", 64'(last_ack_cyc), 64'(cyc - 1));
    checkOutput("t1_ir", 64'(ir), 64'h12345678);
    checkOutput("t1_ir_pc", 64'(ir_pc), 64'h0000);
    checkOutput("t1_next_req", 64'(mem_req), 64'd1);
    checkOutput("t1_next_addr", 64'(mem_addr), 64'h0002);

    // Queue fills with execute stalled, then one pop restarts fetch
    reset_a = 1'b1; latency = 0; applyStimulus(1'b0, 1'b0, 16'h0000);
    stepCycles(2);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'h0000, 32);
    reset_a = 1'b0;
    stepCycles(16);
    checkOutput("t2_level_full", 64'(level), 64'd2);
    checkOutput("t2_req_off", 64'(mem_req), 64'd0);
    checkOutput("t2_ack_count", 64'(ack_addr_q.size()), 64'd4);
    checkOutput("t2_head_pc", 64'(ir_pc), 64'h0000);
    checkOutput("t2_head_ir", 64'(ir), 64'h12345678);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t2_level_after_pop", 64'(level), 64'd1);
    checkOutput("t2_req_after_pop", 64'(mem_req), 64'd1);
    checkOutput("t2_addr_after_pop", 64'(mem_addr), 64'h0004);
    checkOutput("t2_head_pc_after_pop", 64'(ir_pc), 64'h0002);
    checkOutput("t2_pops", 64'(pops_seen), 64'd1);

    // Redirect while the high-word request at address 2 is still outstanding
    reset_a = 1'b1; latency = 3; applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycles(2);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'h0000, 32);
    reset_a = 1'b0;
    for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'h0002); i++) stepCycles(1);
    checkOutput("t3_req_addr2", 64'(mem_req && mem_addr == 16'h0002), 64'd1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 16'h0100);
    exp_q.delete();
    expectStream(16'h0100, 32);
    acks_before = ack_addr_q.size();
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("t3_flush_level", 64'(level), 64'd0);
    checkOutput("t3_flush_valid", 64'(ir_valid), 64'd0);
    for (int i = 0; i < 8 && ack_addr_q.size() == acks_before; i++) begin
      checkOutput("t3_drain_hold", {47'd0, mem_req, mem_addr}, {47'd0, 1'b1, 16'h0002});
      stepCycles(1);
    end
    checkOutput("t3_stale_ack_seen", 64'(ack_addr_q.size()), 64'(acks_before + 1));
    if (ack_addr_q.size() > 0) checkOutput("t3_stale_ack_addr", 64'(ack_addr_q[$]), 64'h0002);
    for (int i = 0; i < 10 && !mem_req; i++) stepCycles(1);
    checkOutput("t3_new_addr", 64'(mem_addr), 64'h0100);
    for (int i = 0; i < 30 && !ir_valid; i++) stepCycles(1);
    checkOutput("t3_ir_pc", 64'(ir_pc), 64'h0100);
    stepCycles(1);
    checkOutput("t3_pops", 64'(pops_seen >= 2), 64'd1);

    // Address wrap from reset PC 0xFFFE (second instance)
    reset_a = 1'b1; sel = 1'b1; reset_b = 1'b1; latency = 0;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycles(2);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'hFFFE, 16);
    reset_b = 1'b0;
    for (int i = 0; i < 30 && pops_seen < 2; i++) stepCycles(1);
    checkOutput("t4_pops", 64'(pops_seen >= 2), 64'd1);
    checkOutput("t4_ack_count", 64'(ack_addr_q.size() >= 3), 64'd1);
    if (ack_addr_q.size() >= 3) begin
      checkOutput("t4_ack0_addr", 64'(ack_addr_q[0]), 64'hFFFE);
      checkOutput("t4_ack1_addr", 64'(ack_addr_q[1]), 64'hFFFF);
      checkOutput("t4_ack2_addr", 64'(ack_addr_q[2]), 64'h0000);
    end
    reset_b = 1'b1;
    stepCycles(1);
    sel = 1'b0;

    // Pop and low-word enqueue in the same cycle with every slot committed
    applyStimulus(1'b0, 1'b0, 16'h0000);
    stepCycles(2);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'h0000, 32);
    reset_a = 1'b0;
    for (int i = 0; i < 20 && level != 2'd1; i++) stepCycles(1);
    checkOutput("t5_level_one", 64'(level), 64'd1);
    checkOutput("t5_hi_addr", 64'(mem_addr), 64'h0002);
    stepCycles(1);
    checkOutput("t5_lo_addr", 64'(mem_addr), 64'h0003);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkOutput("t5_level_kept", 64'(level), 64'd1);
    checkOutput("t5_head_pc", 64'(ir_pc), 64'h0002);
    checkOutput("t5_head_ir", 64'(ir), {32'd0, mem_word(16'h0002), mem_word(16'h0003)});
    checkOutput("t5_next_addr", {47'd0, mem_req, mem_addr}, {47'd0, 1'b1, 16'h0004});
    checkOutput("t5_pops", 64'(pops_seen), 64'd1);

    // Reset during the low-word wait, then an unsolicited ack
    reset_a = 1'b1; latency = 3;
    stepCycles(2);
    exp_q.delete(); ack_addr_q.delete(); pops_seen = 0;
    expectStream(16'h0000, 4);
    reset_a = 1'b0;
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 16'h0001); i++) stepCycles(1);
    checkOutput("t6_in_lo", 64'(mem_req && mem_addr == 16'h0001), 64'd1);
    reset_a = 1'b1;
    #1;
    checkOutput("t6_rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("t6_rst_mem_addr", 64'(mem_addr), 64'h0000);
    checkOutput("t6_rst_ir_valid", 64'(ir_valid), 64'd0);
    checkOutput("t6_rst_level", 64'(level), 64'd0);
    checkOutput("t6_rst_ir", 64'(ir), 64'd0);
    checkOutput("t6_rst_ir_pc", 64'(ir_pc), 64'd0);
    checkOutput("t6_rst_proto_err", 64'(proto_err), 64'd0);
    stepCycles(2);
    reset_a = 1'b0;
    manual_ack = 1'b1;
    stepCycles(1);
    manual_ack = 1'b0;
    checkOutput("t6_proto_err_set", 64'(proto_err), 64'd1);
    stepCycles(5);
    checkOutput("t6_proto_err_sticky", 64'(proto_err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
